// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed/unsigned multiply and divide unit that
// produces HI/LO results through a start/busy/done handshake.
// Multiply is shift-add (one multiplier bit per RUN cycle, LSB first).
// Divide is restoring (one quotient bit per RUN cycle).
// Optional build macro MDU_EARLY_EXIT_EN: multiplies leave RUN as soon as the
// remaining multiplier bits are all zero. Results are the same either way;
// only the latency changes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes; only the signed ops (op[0]==0) look at sign bits.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One multiply step: add the shifted multiplicand when the multiplier LSB is set.
  logic [2*WIDTH-1:0] mul_sum, prod_fix;
  assign mul_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod_fix = neg_res_q ? -mul_sum : mul_sum;

  // One restoring divide step; the borrow out of the WIDTH+1 bit trial
  // subtraction tells whether the divisor fits.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx;
  assign div_shift  = {rem_q, mplier_q[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, mcand_q[WIDTH-1:0]};
  assign div_ge     = ~div_diff[WIDTH];
  assign div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_nx = {mplier_q[WIDTH-2:0], div_ge};

  // Decide whether the current RUN cycle is the last one.
  logic [CW-1:0] cnt_nx;
  logic          last_run;
  assign cnt_nx = cnt_q - 1'b1;
`ifdef MDU_EARLY_EXIT_EN
  assign last_run = (cnt_nx == '0) || (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
  assign last_run = (cnt_nx == '0);
`endif

  // Next-state, datapath and result logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op[1] && (b == '0)) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d   = RUN;
            cnt_d     = CW'(WIDTH);
            is_div_d  = op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            acc_d     = '0;
            rem_d     = '0;
            if (op[1]) begin
              mplier_d = a_mag;
              mcand_d  = {{WIDTH{1'b0}}, b_mag};
            end else begin
              mplier_d = b_mag;
              mcand_d  = {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
      end
      RUN: begin
        cnt_d = cnt_nx;
        if (is_div_q) begin
          rem_d    = div_rem_nx;
          mplier_d = div_quo_nx;
        end else begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (last_run) begin
          state_d = DONE;
          if (is_div_q) begin
            lo_d = neg_res_q ? -div_quo_nx : div_quo_nx;
            hi_d = neg_rem_q ? -div_rem_nx : div_rem_nx;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        dz_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        dz_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against a
// plain-arithmetic reference model (WIDTH=32).
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what HI/LO should hold and how long an op takes.
  logic [W-1:0] expHi = '0, expLo = '0;
  logic         expDz;
  int           expLat;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: full-width arithmetic, SV division truncates toward zero
  // and the remainder follows the dividend sign.
  task automatic modelOp(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint      sa, sb;
    logic [63:0] p;
    logic [W-1:0] mag;
    int          bits;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    expDz  = 1'b0;
    expLat = W + 1;
    case (mop)
      2'b00: begin p = 64'(sa * sb); {expHi, expLo} = p; end
      2'b01: begin p = 64'(ma) * 64'(mb); {expHi, expLo} = p; end
      2'b10: begin
        if (mb == '0) begin expDz = 1'b1; expLat = 1; end
        else begin expLo = W'(sa / sb); expHi = W'(sa % sb); end
      end
      default: begin
        if (mb == '0) begin expDz = 1'b1; expLat = 1; end
        else begin expLo = ma / mb; expHi = ma % mb; end
      end
    endcase
`ifdef MDU_EARLY_EXIT_EN
    if (!mop[1]) begin
      mag  = (mop == 2'b00 && mb[W-1]) ? -mb : mb;
      bits = 0;
      while (bits < W && (mag >> bits) != '0) bits++;
      expLat = ((bits < 1) ? 1 : bits) + 1;
    end
`else
    mag  = '0;
    bits = 0;
`endif
  endtask

  // Wait (bounded) for done; n counts cycles from the accepting edge.
  task automatic waitDone(output int n);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  // Issue one op, wait for it and compare everything against the model.
  task automatic applyStimulus(input string tag, input logic [1:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb);
    int n;
    modelOp(sop, sa, sb);
    @(negedge clock);
    start = 1'b1; op = sop; a = sa; b = sb;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    waitDone(n);
    checkOutput({tag, ".done"}, 64'(done), 64'(1));
    checkOutput({tag, ".latency"}, 64'(n), 64'(expLat));
    checkOutput({tag, ".hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, ".lo"}, 64'(lo), 64'(expLo));
    checkOutput({tag, ".div_zero"}, 64'(div_zero), 64'(expDz));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(1));
    @(posedge clock); #1;
    checkOutput({tag, ".done_pulse"}, 64'(done), 64'(0));
    checkOutput({tag, ".idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int           n, pulses;
    logic [W-1:0] ra, rb, firstHi, firstLo;
    logic [1:0]   rop;

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset.busy", 64'(busy), 64'(0));
    checkOutput("reset.done", 64'(done), 64'(0));
    checkOutput("reset.div_zero", 64'(div_zero), 64'(0));
    checkOutput("reset.hi", 64'(hi), 64'(0));
    checkOutput("reset.lo", 64'(lo), 64'(0));
    @(negedge clock) reset = 1'b1;

    // Directed vectors with hand-derived results.
    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu_max.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    checkOutput("multu_max.lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    applyStimulus("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3);
    checkOutput("mult_neg.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    checkOutput("mult_neg.lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    applyStimulus("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_neg.lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    checkOutput("div_neg.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_ovf.lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    checkOutput("div_ovf.hi_const", 64'(hi), 64'h0);
    applyStimulus("divu_zero", 2'b11, 32'h0000_1234, 32'h0);
    checkOutput("divu_zero.lo_kept", 64'(lo), 64'h0000_0000_8000_0000);
    checkOutput("divu_zero.hi_kept", 64'(hi), 64'h0);
    applyStimulus("multu_small", 2'b01, 32'd6, 32'd5);
    checkOutput("multu_small.lo_const", 64'(lo), 64'd30);
    applyStimulus("multu_bzero", 2'b01, 32'd12345, 32'd0);
    checkOutput("multu_bzero.lo_const", 64'(lo), 64'd0);
    applyStimulus("divu_basic", 2'b11, 32'd100, 32'd7);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = (i % 4 == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      rb  = (i % 3 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      if (i % 8 == 5) rb = '0;
      applyStimulus($sformatf("rand%0d", i), rop, ra, rb);
    end

    // Reset in the middle of a MULTU: abort with no done pulse afterwards.
    @(negedge clock);
    start = 1'b1; op = 2'b01; a = W'($urandom); b = W'($urandom);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("abort.busy", 64'(busy), 64'(0));
    checkOutput("abort.done", 64'(done), 64'(0));
    checkOutput("abort.hi", 64'(hi), 64'(0));
    checkOutput("abort.lo", 64'(lo), 64'(0));
    expHi = '0; expLo = '0;
    @(negedge clock) reset = 1'b1;
    pulses = 0;
    repeat (2 * W) begin
      @(posedge clock); #1;
      if (done === 1'b1) pulses++;
    end
    checkOutput("abort.no_done", 64'(pulses), 64'(0));
    applyStimulus("after_abort", 2'b00, W'($urandom), W'($urandom));

    // start held high through a DIVU with operands churning: one done only,
    // then the next op is taken in the IDLE cycle that follows DONE.
    modelOp(2'b11, 32'hDEAD_BEEF, 32'h0000_0123);
    firstHi = expHi; firstLo = expLo;
    @(negedge clock);
    start = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h0000_0123;
    @(posedge clock); #1;
    n = 1; pulses = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clock);
      op = 2'($urandom); a = W'($urandom); b = W'($urandom) | 32'h1;
      @(posedge clock); #1;
      n++;
    end
    checkOutput("hold.latency", 64'(n), 64'(W + 1));
    checkOutput("hold.hi", 64'(hi), 64'(firstHi));
    checkOutput("hold.lo", 64'(lo), 64'(firstLo));
    @(negedge clock);
    op = 2'b01; a = 32'h0001_0003; b = 32'h0000_0011;
    modelOp(2'b01, 32'h0001_0003, 32'h0000_0011);
    @(posedge clock); #1;
    checkOutput("hold.gap_busy", 64'(busy), 64'(0));
    checkOutput("hold.gap_done", 64'(done), 64'(0));
    @(posedge clock); #1;
    checkOutput("hold.accept_busy", 64'(busy), 64'(1));
    start = 1'b0;
    waitDone(n);
    checkOutput("hold.second_latency", 64'(n), 64'(expLat));
    checkOutput("hold.second_hi", 64'(hi), 64'(expHi));
    checkOutput("hold.second_lo", 64'(lo), 64'(expLo));
    @(posedge clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
